// File: rtl/grey_pkg.sv
// grey_pkg: width defaults plus grey decode and popcount helpers for grey_ptr_sync (GREY_SYNC_ERR_CHECK_EN).
package grey_pkg;
  localparam int DEF_N = 8;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic logic [31:0] grey_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/grey_to_bin_nbits.sv
// grey_to_bin_nbits: combinational N-bit grey-to-binary decoder.
module grey_to_bin_nbits import grey_pkg::*; #(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] g,
  output logic [N-1:0] b
);
  assign b = N'(grey_to_bin(32'(g)));
endmodule

// File: rtl/grey_ptr_sync.sv
// grey_ptr_sync: grey pointer CDC synchroniser with binary decode, delta and optional multi-bit error flag (GREY_SYNC_ERR_CHECK_EN).
module grey_ptr_sync import grey_pkg::*; #(
  parameter int N = DEF_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] grey_async,
  input  logic         err_clr,
  output logic [N-1:0] grey_sync,
  output logic [N-1:0] bin_out,
  output logic         upd,
  output logic [N-1:0] delta,
  output logic         err
);
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];
  logic [N-1:0] prev_q, prev_d, bin_q, bin_d, delta_q, delta_d, dec;
  logic         upd_q, upd_d, changed;
  assign sync_d[0] = grey_async;
  for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_chain
    assign sync_d[s] = sync_q[s-1];
  end
  assign grey_sync = sync_q[SYNC_STAGES-1];
  grey_to_bin_nbits #(.N(N)) u_dec (.g(grey_sync), .b(dec));
  always_comb begin
    changed = grey_sync != prev_q;
    prev_d  = grey_sync;
    bin_d   = changed ? dec : bin_q;
    delta_d = changed ? dec - bin_q : delta_q;
    upd_d   = changed;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '{default: '0};
      prev_q  <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      upd_q   <= upd_d;
    end
  end
  assign bin_out = bin_q;
  assign delta   = delta_q;
  assign upd     = upd_q;
`ifdef GREY_SYNC_ERR_CHECK_EN
  logic err_q, err_d;
  // a fresh multi-bit error takes priority over a coincident clear
  always_comb err_d = (changed && popcount(32'(grey_sync ^ prev_q)) > 1) ? 1'b1 : err_clr ? 1'b0 : err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_grey_ptr_sync.sv
// tb_grey_ptr_sync: directed plus random checks of grey_ptr_sync against a history-based reference model.
module tb_grey_ptr_sync;
  localparam int N = 8;
  localparam int S = 2;
  logic clk = 1'b0, rst_n = 1'b1, err_clr = 1'b0;
  logic [N-1:0] grey_async = '0;
  logic [N-1:0] grey_sync, bin_out, delta;
  logic upd, err;
  int tests = 0, fails = 0, t = 0;
  logic [N-1:0] in_h [0:8191];
  logic [N-1:0] inv [0:255];
  logic [N-1:0] m_delta = '0;
  logic m_err = 1'b0;
  logic [N-1:0] cur;
  always #5 clk = ~clk;
  grey_ptr_sync #(.N(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .grey_async(grey_async), .err_clr(err_clr),
    .grey_sync(grey_sync), .bin_out(bin_out), .upd(upd), .delta(delta), .err(err)
  );
  function automatic logic [N-1:0] gs(input int k);
    return (k - S + 1 >= 1) ? in_h[k-S+1] : '0;
  endfunction
  task automatic chk(input string tag, input logic [N-1:0] o, input logic [N-1:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s t=%0d got %h want %h", tag, t, o, e);
    end
  endtask
  task automatic chk_zero(input string when);
    chk({when, ".grey_sync"}, grey_sync, '0);
    chk({when, ".bin_out"}, bin_out, '0);
    chk({when, ".upd"}, {7'd0, upd}, '0);
    chk({when, ".delta"}, delta, '0);
    chk({when, ".err"}, {7'd0, err}, '0);
  endtask
  task automatic step(input logic [N-1:0] g, input logic c);
    logic [N-1:0] a, b;
    logic ch;
    grey_async = g;
    err_clr = c;
    @(posedge clk);
    t++;
    in_h[t] = g;
    a = gs(t - 1);
    b = gs(t - 2);
    ch = a != b;
    if (ch) m_delta = inv[a] - inv[b];
`ifdef GREY_SYNC_ERR_CHECK_EN
    m_err = (ch && $countones(a ^ b) > 1) ? 1'b1 : c ? 1'b0 : m_err;
`else
    m_err = 1'b0;
`endif
    #1;
    chk("grey_sync", grey_sync, gs(t));
    chk("bin_out", bin_out, inv[a]);
    chk("upd", {7'd0, upd}, {7'd0, ch});
    chk("delta", delta, m_delta);
    chk("err", {7'd0, err}, {7'd0, m_err});
  endtask
  task automatic do_reset(input string when);
    #2 rst_n = 1'b0;
    #1 chk_zero(when);
    t = 0;
    m_delta = '0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    for (int b = 0; b < 256; b++) inv[8'(b ^ (b >> 1))] = 8'(b);
    grey_async = 8'h5a;
    do_reset("por");
    grey_async = '0;
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0);
    step(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h01, 1'b0);
    for (int b = 0; b < 256; b++) step(8'(b ^ (b >> 1)), 1'b0);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0);
    step(8'h03, 1'b0);
    for (int i = 0; i < 4; i++) step(8'h03, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    cur = '0;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) cur[$urandom_range(0, N-1)] ^= 1'b1;
      else if (r >= 8) cur = 8'($urandom);
      step(cur, $urandom_range(0, 9) == 0);
    end
    step(8'h55, 1'b0);
    do_reset("midrun");
    for (int i = 0; i < 5; i++) step(8'h55, 1'b0);
    step(8'h54, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h54, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grey_ptr_sync.md
GREY_PTR_SYNC -- requirements
Module: grey_ptr_sync

Interface
REQ-001 SHALL have parameter N, default 8, pointer width in bits (N >= 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops (SYNC_STAGES >= 2).
REQ-003 SHALL have port clk  input  1  destination-domain clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port grey_async  input  N  grey-coded pointer from a foreign clock domain.
REQ-006 SHALL have port err_clr  input  1  synchronous clear of the sticky error flag.
REQ-007 SHALL have port grey_sync  output  N  final synchroniser stage value.
REQ-008 SHALL have port bin_out  output  N  registered binary decode of grey_sync.
REQ-009 SHALL have port upd  output  1  one-cycle pulse when bin_out takes a new value.
REQ-010 SHALL have port delta  output  N  (new bin_out - previous bin_out) mod 2^N, valid with upd.
REQ-011 SHALL have port err  output  1  sticky flag: a synced sample changed more than one bit.

Function
REQ-012 SHALL capture grey_async into stage 0 each edge and shift through SYNC_STAGES flops; grey_sync = last stage.
REQ-013 SHALL decode grey to binary as b[N-1]=g[N-1], b[i]=b[i+1]^g[i], on grey_sync.
REQ-014 SHALL hold a prev_grey register, loaded with grey_sync every edge.
REQ-015 SHALL, when grey_sync != prev_grey: load bin_out with the decode, assert upd next cycle, load delta = decode - bin_out (mod 2^N).
REQ-016 SHALL, when grey_sync == prev_grey: hold bin_out and delta, deassert upd.
REQ-017 Latency: input stable before edge 1 -> grey_sync after edge SYNC_STAGES -> bin_out/upd after edge SYNC_STAGES+1.
REQ-018 Wrap-around (decode 2^N-1 -> 0) SHALL give delta = 1, with no error.
REQ-019 SHALL set err on the same edge as the update when popcount(grey_sync ^ prev_grey) > 1; bin_out still updates.
REQ-020 err SHALL stay set until err_clr is sampled high; with a simultaneous new error and err_clr, set SHALL win.
REQ-021 upd SHALL never be high for two consecutive cycles unless grey_sync changes on consecutive cycles.

Reset
REQ-022 rst_n low SHALL asynchronously clear all sync stages, prev_grey, bin_out, delta, upd and err to 0.
REQ-023 Reset deassertion SHALL be synchronous to clk externally; the first post-reset sample SHALL be compared against prev_grey = 0.
REQ-024 Reset mid-operation SHALL discard in-flight samples; no upd pulse SHALL be produced for them.

Configuration
REQ-025 Macro GREY_SYNC_ERR_CHECK_EN defined: popcount checker and err logic present per REQ-019/020.
REQ-026 Macro undefined: err tied to 0, err_clr ignored, checker logic absent; all other behaviour unchanged.

Structure
REQ-027 Shared package grey_pkg SHALL hold default width constants and the grey_to_bin and popcount functions.
REQ-028 The combinational decoder SHALL be a sub-module grey_to_bin_nbits (parameter N), instantiated once.
REQ-029 The synchroniser chain SHALL be a plain flop array in this module, with no logic between stages.

Verification (N=8, SYNC_STAGES=2)
REQ-030 Reset: rst_n low mid-run with nonzero data -> all outputs 0 immediately, before any clock edge.
REQ-031 Step: grey_async 0x00->0x01 -> bin_out=0x01, upd high exactly one cycle after edge 3, delta=0x01, err=0.
REQ-032 Wrap: full grey count ending 0x80 (bin 255) -> 0x00 -> bin_out=0x00, delta=0x01, err=0 throughout.
REQ-033 Multi-bit jump: 0x00->0x03 -> bin_out=0x02, delta=0x02, err=1 and stays 1.
REQ-034 Clear race: err_clr high on the same edge as a new two-bit jump -> err remains 1; next err_clr alone -> err=0.
REQ-035 Macro off: repeat REQ-033 -> bin_out=0x02, delta=0x02, err=0.
